// File: rtl/adc_pulse_emulator.sv
// ============================================================================
// adc_pulse_emulator : AXI4-Stream ADC word generator (baseline, noise, decaying pulses)
// Revision 1.0
// ============================================================================
`default_nettype none

module adc_pulse_emulator #(
   parameter int BASELINE_VAL         = 100,
   parameter int PULSE_HEIGHT         = 1000,
   parameter int PULSE_PERIOD         = 8,
   parameter int PULSE_WIDTH          = 2,
   parameter int DECAY_SHIFT          = 1,
   parameter int NOISE_EN             = 0,
   parameter int FREE_RUN             = 0,
   parameter int ADC_RESOLUTION_WIDTH = 12,
   parameter int M_AXIS_TDATA_WIDTH   = 128
) (
   input  logic                          AXIS_ACLK,
   input  logic                          AXIS_ARESETN,
   input  logic                          EN,
   output logic [M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
   output logic                          M_AXIS_TVALID,
   input  logic                          M_AXIS_TREADY,
   output logic                          O_PULSE_ACTIVE,
   output logic [15:0]                   O_PULSE_COUNT
);

   localparam int ADC_W  = ADC_RESOLUTION_WIDTH;
   localparam int SUM_W  = ADC_W + 2;
   localparam int LANES  = M_AXIS_TDATA_WIDTH / 16;
   localparam int CNT_W  = $clog2(PULSE_PERIOD + 1);
   localparam logic [CNT_W-1:0] LAST_BASE   = CNT_W'(PULSE_PERIOD - PULSE_WIDTH - 1);
   localparam logic [CNT_W-1:0] FIRST_PULSE = CNT_W'(PULSE_PERIOD - PULSE_WIDTH);
   localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(PULSE_PERIOD - 1);
   localparam logic [SUM_W-1:0] SAT_MAX     = SUM_W'((1 << ADC_W) - 1);
   localparam logic [15:0]      LFSR_SEED   = 16'hACE1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BASE  = 2'd1,
      ST_PULSE = 2'd2
   } state_t;

   state_t                          state_q, state_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [ADC_W-1:0]                amp_q, amp_d;
   logic [15:0]                     lfsr_q, lfsr_d;
   logic [15:0]                     pulse_count_q, pulse_count_d;
   logic                            tvalid_q, tvalid_d;
   logic                            active_q, active_d;
   logic [M_AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
   logic                            adv;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   // Each lane: baseline + amp + per-lane noise, clipped to full scale, MSB-aligned in 16 bits.
   function automatic logic [M_AXIS_TDATA_WIDTH-1:0] build_word(
      input logic             use_amp,
      input logic [ADC_W-1:0] amp,
      input logic [15:0]      lfsr
   );
      logic [M_AXIS_TDATA_WIDTH-1:0] w;
      logic [SUM_W-1:0]              sum;
      logic [SUM_W-1:0]              noise;
      logic [ADC_W-1:0]              smp;
      w = '0;
      for (int i = 0; i < LANES; i++) begin
         noise = (NOISE_EN != 0) ? SUM_W'(lfsr[(2*i)%16 +: 2]) : '0;
         sum   = SUM_W'(BASELINE_VAL) + (use_amp ? SUM_W'(amp) : '0) + noise;
         smp   = (sum > SAT_MAX) ? SAT_MAX[ADC_W-1:0] : sum[ADC_W-1:0];
         w[16*i +: 16] = {smp, {(16-ADC_W){1'b0}}};
      end
      return w;
   endfunction

   assign adv = tvalid_q & ((FREE_RUN != 0) | M_AXIS_TREADY);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      amp_d         = amp_q;
      lfsr_d        = lfsr_q;
      pulse_count_d = pulse_count_q;
      tvalid_d      = tvalid_q;
      active_d      = active_q;
      tdata_d       = tdata_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            amp_d = '0;
            if (EN) begin
               state_d  = ST_BASE;
               tvalid_d = 1'b1;
               active_d = 1'b0;
               tdata_d  = build_word(1'b0, '0, lfsr_q);
            end
         end
         default: begin
            if (adv) begin
               lfsr_d = lfsr_step(lfsr_q);
               if (state_q == ST_PULSE && cnt_q == FIRST_PULSE) begin
                  pulse_count_d = pulse_count_q + 16'd1;
               end
               if (!EN) begin
                  state_d  = ST_IDLE;
                  tvalid_d = 1'b0;
                  active_d = 1'b0;
                  tdata_d  = '0;
                  cnt_d    = '0;
                  amp_d    = '0;
               end else begin
                  if (state_q == ST_BASE) begin
                     cnt_d = cnt_q + 1'b1;
                     if (cnt_q == LAST_BASE) begin
                        state_d = ST_PULSE;
                        amp_d   = ADC_W'(PULSE_HEIGHT);
                     end
                  end else begin
                     amp_d = amp_q - (amp_q >> DECAY_SHIFT);
                     if (cnt_q == LAST_WORD) begin
                        cnt_d   = '0;
                        state_d = ST_BASE;
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
                  active_d = (state_d == ST_PULSE);
                  tdata_d  = build_word(state_d == ST_PULSE, amp_d, lfsr_d);
               end
            end
         end
      endcase
   end

   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         amp_q         <= '0;
         lfsr_q        <= LFSR_SEED;
         pulse_count_q <= '0;
         tvalid_q      <= 1'b0;
         active_q      <= 1'b0;
         tdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         amp_q         <= amp_d;
         lfsr_q        <= lfsr_d;
         pulse_count_q <= pulse_count_d;
         tvalid_q      <= tvalid_d;
         active_q      <= active_d;
         tdata_q       <= tdata_d;
      end
   end

   assign M_AXIS_TDATA   = tdata_q;
   assign M_AXIS_TVALID  = tvalid_q;
   assign O_PULSE_ACTIVE = active_q;
   assign O_PULSE_COUNT  = pulse_count_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_pulse_emulator.sv
// ============================================================================
// tb_adc_pulse_emulator : three emulator configurations against a word-index reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_adc_pulse_emulator;

   localparam int P  = 8;
   localparam int W  = 2;
   localparam int PH = 1000;
   localparam int DS = 1;
   localparam int NI = 3;
   localparam int BASEV [NI] = '{100, 4000, 100};
   localparam int NOISE [NI] = '{0, 0, 1};
   localparam int FREE  [NI] = '{0, 0, 1};

   logic clk;
   logic rst_n;
   logic en;
   logic tready;
   logic [NI-1:0][127:0] tdata_w;
   logic [NI-1:0]        tvalid_w;
   logic [NI-1:0]        active_w;
   logic [NI-1:0][15:0]  cnt_w;

   int passed = 0;
   int total  = 0;

   // reference model: word index within the period, LFSR value and pulse tally
   int          m_valid [NI];
   int          m_n     [NI];
   logic [15:0] m_lfsr  [NI];
   logic [15:0] m_cnt   [NI];

   adc_pulse_emulator u_def (
      .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .EN(en),
      .M_AXIS_TDATA(tdata_w[0]), .M_AXIS_TVALID(tvalid_w[0]), .M_AXIS_TREADY(tready),
      .O_PULSE_ACTIVE(active_w[0]), .O_PULSE_COUNT(cnt_w[0]));

   adc_pulse_emulator #(.BASELINE_VAL(4000)) u_sat (
      .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .EN(en),
      .M_AXIS_TDATA(tdata_w[1]), .M_AXIS_TVALID(tvalid_w[1]), .M_AXIS_TREADY(tready),
      .O_PULSE_ACTIVE(active_w[1]), .O_PULSE_COUNT(cnt_w[1]));

   adc_pulse_emulator #(.NOISE_EN(1), .FREE_RUN(1)) u_nf (
      .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n), .EN(en),
      .M_AXIS_TDATA(tdata_w[2]), .M_AXIS_TVALID(tvalid_w[2]), .M_AXIS_TREADY(tready),
      .O_PULSE_ACTIVE(active_w[2]), .O_PULSE_COUNT(cnt_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   function automatic int amp_of(input int n);
      int a;
      if (n < P - W) return 0;
      a = PH;
      for (int j = 0; j < n - (P - W); j++) a = a - (a >> DS);
      return a;
   endfunction

   function automatic logic [127:0] exp_word(input int i);
      logic [127:0] w;
      int s;
      w = '0;
      for (int k = 0; k < 8; k++) begin
         s = BASEV[i] + amp_of(m_n[i]) + (NOISE[i] != 0 ? int'(m_lfsr[i][2*k +: 2]) : 0);
         if (s > 4095) s = 4095;
         w[16*k +: 16] = 16'(s << 4);
      end
      return w;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_valid[i] = 0;
         m_n[i]     = 0;
         m_lfsr[i]  = 16'hACE1;
         m_cnt[i]   = 16'd0;
      end
   endtask

   task automatic model_clock();
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            m_valid[i] = 0; m_n[i] = 0; m_lfsr[i] = 16'hACE1; m_cnt[i] = 16'd0;
         end else if (m_valid[i] == 0) begin
            if (en) begin m_valid[i] = 1; m_n[i] = 0; end
         end else if (tready || FREE[i] != 0) begin
            m_lfsr[i] = lfsr_next(m_lfsr[i]);
            if (m_n[i] == P - W) m_cnt[i] = m_cnt[i] + 16'd1;
            if (!en) m_valid[i] = 0;
            else m_n[i] = (m_n[i] + 1) % P;
         end
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("tvalid[%0d]", i), 128'(tvalid_w[i]), 128'(m_valid[i] != 0));
         chk($sformatf("pulse_count[%0d]", i), 128'(cnt_w[i]), 128'(m_cnt[i]));
         if (m_valid[i] != 0) begin
            chk($sformatf("tdata[%0d] n=%0d", i, m_n[i]), tdata_w[i], exp_word(i));
            chk($sformatf("active[%0d]", i), 128'(active_w[i]), 128'(m_n[i] >= P - W));
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_clock();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      logic [127:0] lit;
      logic         found;
      rst_n = 1'b0; en = 1'b0; tready = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset tvalid", 128'(tvalid_w), 128'(0));
      chk("reset tdata0", tdata_w[0], 128'(0));
      chk("reset count0", 128'(cnt_w[0]), 128'(0));
      compare_all();

      rst_n = 1'b1; en = 1'b1;
      step();
      chk("word0 default", tdata_w[0], {8{16'h0640}});
      chk("word0 baseline4000", tdata_w[1], {8{16'hFA00}});
      lit = tdata_w[2];
      chk("noise lanes0-3", 128'(lit[63:0]), 128'(64'h0670_0660_0640_0650));
      repeat (6) step();
      chk("word6 pulse", tdata_w[0], {8{16'h44C0}});
      chk("word6 active", 128'(active_w[0]), 128'(1));
      chk("word6 count", 128'(cnt_w[0]), 128'(0));
      chk("word6 saturated", tdata_w[1], {8{16'hFFF0}});

      tready = 1'b0;
      repeat (5) begin
         step();
         chk("stall hold data", tdata_w[0], {8{16'h44C0}});
         chk("stall hold count", 128'(cnt_w[0]), 128'(0));
      end
      tready = 1'b1;
      step();
      chk("word7 decay", tdata_w[0], {8{16'h2580}});
      chk("count after word6", 128'(cnt_w[0]), 128'(1));

      en = 1'b0; tready = 1'b0;
      repeat (3) begin
         step();
         chk("en-low held valid", 128'(tvalid_w[0]), 128'(1));
         chk("en-low held data", tdata_w[0], {8{16'h2580}});
      end
      tready = 1'b1;
      step();
      chk("en-low idle", 128'(tvalid_w[0]), 128'(0));
      chk("en-low count kept", 128'(cnt_w[0]), 128'(1));
      en = 1'b1;
      repeat (20) step();

      for (int c = 0; c < 400; c++) begin
         en     = ($urandom_range(0, 19) != 0);
         tready = ($urandom_range(0, 3) != 0);
         step();
      end

      en = 1'b1; tready = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         step();
         found = active_w[0];
      end
      chk("reach pulse before reset", 128'(found), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async rst tvalid", 128'(tvalid_w), 128'(0));
      chk("async rst tdata", tdata_w[0], 128'(0));
      chk("async rst active", 128'(active_w), 128'(0));
      chk("async rst count", 128'(cnt_w[0]), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("restart word0", tdata_w[0], {8{16'h0640}});
      repeat (16) step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
